// File: rtl/mem_resp_pkg.sv
// Shared types and constants for mem_responder: FSM states, access size, wait counter width.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        SZ_WORD = 1'b0,
        SZ_BYTE = 1'b1
    } size_t;

    localparam int CNT_W = 4;

    // Counter load value on accept; zero wait states bypass WAIT so the value is unused.
    function automatic logic [CNT_W-1:0] wait_init(input int wait_cycles);
        return (wait_cycles > 0) ? CNT_W'(wait_cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane extract (sign-extended) and merge for 32-bit words; purely combinational.
module mem_lane_unit
    import mem_resp_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic        i_byte,
    output logic [31:0] o_merged,
    output logic [31:0] o_rbyte
);

    logic [7:0] w_lane_byte;

    always_comb begin
        w_lane_byte = i_word[8*i_lane +: 8];
        o_rbyte     = {{24{w_lane_byte[7]}}, w_lane_byte};
        o_merged    = i_wdata;
        if (i_byte) begin
            o_merged                  = i_word;
            o_merged[8*i_lane +: 8]   = i_wdata[7:0];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word/byte memory responder; response WAIT_CYCLES+1 cycles after accept, held until rsp_ready,
// no accept while busy. Define MEM_RESPONDER_ALIGN_CHECK_EN to reject misaligned word accesses.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int             AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = wait_init(WAIT_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wr;
    size_t              r_size;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_commit;
    logic               w_acc_wr;
    size_t              w_acc_size;
    logic [31:0]        w_acc_addr;
    logic [31:0]        w_acc_wdata;
    logic [29:0]        w_idx;
    logic [AW-1:0]      w_mem_idx;
    logic               w_oob;
    logic               w_misalign;
    logic               w_fail;
    logic [31:0]        w_cur_word;
    logic [31:0]        w_merged;
    logic [31:0]        w_rbyte;
    logic [31:0]        w_rsp_rdata;

    assign w_accept = (r_state == IDLE) && req_valid && !reset;

    // With no wait states the access commits on the accept edge, straight from the request pins.
    assign w_commit    = (WAIT_CYCLES == 0) ? w_accept : ((r_state == WAIT) && (r_cnt == '0));
    assign w_acc_wr    = (WAIT_CYCLES == 0) ? req_wr            : r_wr;
    assign w_acc_size  = (WAIT_CYCLES == 0) ? size_t'(req_byte) : r_size;
    assign w_acc_addr  = (WAIT_CYCLES == 0) ? req_addr          : r_addr;
    assign w_acc_wdata = (WAIT_CYCLES == 0) ? req_wdata         : r_wdata;

    assign w_idx      = w_acc_addr[31:2];
    assign w_oob      = (w_idx >= 30'(DEPTH_WORDS));
    assign w_mem_idx  = w_idx[AW-1:0];
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign w_misalign = (w_acc_size == SZ_WORD) && (w_acc_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_fail     = w_oob | w_misalign;
    assign w_cur_word = r_mem[w_mem_idx];

    mem_lane_unit u_lane (
        .i_word   (w_cur_word),
        .i_lane   (w_acc_addr[1:0]),
        .i_wdata  (w_acc_wdata),
        .i_byte   (w_acc_size == SZ_BYTE),
        .o_merged (w_merged),
        .o_rbyte  (w_rbyte)
    );

    always_comb begin
        w_rsp_rdata = '0;
        if (!w_fail && !w_acc_wr) begin
            w_rsp_rdata = (w_acc_size == SZ_BYTE) ? w_rbyte : w_cur_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == '0) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE);
        rsp_valid = (r_state == RESP);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_size  <= SZ_WORD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_wr    <= req_wr;
                r_size  <= size_t'(req_byte);
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_rdata <= w_rsp_rdata;
                r_err   <= w_fail;
            end
        end
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_commit && w_acc_wr && !w_fail) begin
            r_mem[w_mem_idx] <= w_merged;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance against a word-array model.
module tb_mem_responder;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid, req_ready, req_wr, req_byte, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [2][256];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_byte(req_byte[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_byte(req_byte[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed accesses on an array of words, little-endian lanes.
    function automatic void model(input int d, input bit wr, input bit byt,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output bit err);
        int unsigned idx  = addr >> 2;
        int          lane = int'(addr % 4);
        logic [31:0] w;
        logic [7:0]  b;
        err = (idx >= 256);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        if (!byt && lane != 0) err = 1'b1;
`endif
        rd = '0;
        if (err) return;
        w = mdl[d][idx];
        if (wr) begin
            if (byt) mdl[d][idx] = (w & ~(32'hFF << (8*lane))) | ((wdata & 32'hFF) << (8*lane));
            else     mdl[d][idx] = wdata;
        end else begin
            b  = 8'((w >> (8*lane)) & 32'hFF);
            rd = byt ? {{24{b[7]}}, b} : w;
        end
    endfunction

    task automatic txn(input int d, input bit wr, input bit byt, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input bit keep,
                       output logic [31:0] rd, output logic er);
        int          lat;
        logic [31:0] exp_rd;
        bit          exp_er;
        model(d, wr, byt, addr, wdata, exp_rd, exp_er);
        @(negedge clk);
        chk("ready_idle", req_ready[d], 1);
        req_valid[d] = 1'b1; req_wr[d] = wr; req_byte[d] = byt;
        req_addr[d] = addr; req_wdata[d] = wdata; rsp_ready[d] = 1'b0;
        @(posedge clk); #1;
        if (!keep) req_valid[d] = 1'b0;
        req_wr[d] = ~wr; req_byte[d] = ~byt; req_addr[d] = $urandom; req_wdata[d] = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[d] && lat < 40);
        chk("latency", lat, (d == 0) ? 3 : 1);
        rd = rsp_rdata[d];
        er = rsp_err[d];
        chk("rdata", rd, exp_rd);
        chk("err", er, exp_er);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid[d], 1);
            chk("hold_rdata", rsp_rdata[d], rd);
            chk("hold_err", rsp_err[d], er);
            chk("busy_ready", req_ready[d], 0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", rsp_valid[d], 0);
        chk("post_hs_ready", req_ready[d], 1);
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, old, a, exp_rd;
        logic        er;
        bit          exp_er, wr, byt;

        reset = 1'b1;
        req_valid = '0; rsp_ready = '0; req_wr = '0; req_byte = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", req_ready[d], 1);
            chk("rst_rsp_valid", rsp_valid[d], 0);
            chk("rst_rsp_rdata", rsp_rdata[d], 0);
            chk("rst_rsp_err", rsp_err[d], 0);
        end
        reset = 1'b0;

        txn(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, rd, er);
        chk("wr_rdata_zero", rd, 0);
        txn(0, 0, 0, 32'h10, 0, 0, 0, rd, er);
        chk("word_read", rd, 32'hDEADBEEF);
        chk("word_read_err", er, 0);

        txn(0, 1, 0, 32'h20, 32'h11223344, 0, 0, rd, er);
        txn(0, 1, 1, 32'h22, 32'h000000AA, 0, 0, rd, er);
        txn(0, 0, 0, 32'h20, 0, 0, 0, rd, er);
        chk("merged_word", rd, 32'h11AA3344);
        txn(0, 0, 1, 32'h22, 0, 0, 0, rd, er);
        chk("byte_neg", rd, 32'hFFFFFFAA);
        txn(0, 0, 1, 32'h23, 0, 0, 0, rd, er);
        chk("byte_pos", rd, 32'h00000011);

        txn(0, 0, 0, 32'h400, 0, 0, 0, rd, er);
        chk("oob_err", er, 1);
        chk("oob_rdata", rd, 0);
        txn(0, 1, 0, 32'h12, 32'h55667788, 0, 0, rd, er);
        txn(0, 0, 0, 32'h10, 0, 0, 0, rd, er);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        chk("misalign_unchanged", rd, 32'hDEADBEEF);
`else
        chk("misalign_ignored", rd, 32'h55667788);
`endif

        txn(0, 0, 0, 32'h20, 0, 5, 1, rd, er);
        chk("stall_rdata", rd, 32'h11AA3344);

        for (int i = 0; i < 16; i++) txn(0, 1, 0, 32'(i * 4), $urandom, 0, 0, rd, er);

        // Reset during WAIT abandons the write.
        old = mdl[0][15];
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_byte[0] = 1'b0;
        req_addr[0] = 32'h3C; req_wdata[0] = ~old;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_wait_ready", req_ready[0], 1);
        chk("rst_wait_valid", rsp_valid[0], 0);
        @(negedge clk);
        reset = 1'b0;
        txn(0, 0, 0, 32'h3C, 0, 0, 0, rd, er);
        chk("rst_wait_nowrite", rd, old);

        // Reset during RESP drops the response.
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 32'h3C;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("resp_pending", rsp_valid[0], 1);
        reset = 1'b1;
        #1;
        chk("rst_resp_valid", rsp_valid[0], 0);
        chk("rst_resp_rdata", rsp_rdata[0], 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            wr  = 1'($urandom_range(0, 1));
            byt = 1'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a + 32'h400 + ($urandom & 32'h00FF_FC00);
            txn(0, wr, byt, a, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd, er);
        end

        for (int i = 0; i < 8; i++) txn(1, 1, 0, 32'(i * 4), $urandom, 0, 0, rd, er);
        for (int i = 0; i < 8; i++) txn(1, 1, 1, 32'($urandom_range(0, 31)), $urandom, 0, 0, rd, er);

        // Back-to-back reads with zero wait states: response every other cycle.
        @(negedge clk);
        req_valid[1] = 1'b1; rsp_ready[1] = 1'b1; req_wr[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            byt = 1'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 31));
            req_byte[1] = byt; req_addr[1] = a;
            model(1, 0, byt, a, 0, exp_rd, exp_er);
            @(negedge clk);
            chk("b2b_valid", rsp_valid[1], 1);
            chk("b2b_rdata", rsp_rdata[1], exp_rd);
            chk("b2b_err", rsp_err[1], exp_er);
            chk("b2b_busy", req_ready[1], 0);
            @(negedge clk);
            chk("b2b_gap", rsp_valid[1], 0);
            chk("b2b_ready", req_ready[1], 1);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL take a parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words (power of two).
REQ-002 The module SHALL take a parameter WAIT_CYCLES, default 2, giving the wait states inserted between accept and response (range 0-15).
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset, with ports named as below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_wr  input  1  1 = write, 0 = read.
REQ-009 req_byte  input  1  1 = byte access, 0 = word access.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  write data; for byte writes, bits [7:0] are used.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator consumes the response.
REQ-014 rsp_rdata  output  32  read data; 0 for writes and for errors.
REQ-015 rsp_err  output  1  access failed; no write was performed.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on the rising edge where req_valid and req_ready are both 1.
REQ-018 On accept, the responder SHALL latch wr, byte, addr and wdata; it then moves to WAIT with the counter set to WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0.
REQ-019 In WAIT, the counter SHALL decrement every cycle; when the counter is 0, the access commits and the FSM moves to RESP.
REQ-020 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-021 rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1, and the FSM returns to IDLE on that edge.
REQ-022 A new request SHALL NOT be accepted on the same edge as the response handshake.
REQ-023 Word index = addr[31:2]. An index >= DEPTH_WORDS SHALL give rsp_err=1, rsp_rdata=0 and no write.
REQ-024 A word read SHALL return the stored word.
REQ-025 A byte read SHALL return the lane selected by addr[1:0], sign-extended to 32 bits; lane 0 is bits [7:0] and lane 3 is bits [31:24].
REQ-026 A word write SHALL replace the whole word.
REQ-027 A byte write SHALL replace only the lane selected by addr[1:0] with wdata[7:0].
REQ-028 Every write SHALL commit exactly once, at the WAIT-to-RESP transition (or the IDLE-to-RESP transition when WAIT_CYCLES=0).
REQ-029 A read following a write to the same word SHALL observe the new data.
REQ-030 req_* changes while not in IDLE SHALL be ignored.

Reset
REQ-031 Reset SHALL force IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0 immediately, independent of clk.
REQ-032 Storage contents SHALL NOT be cleared by reset.
REQ-033 Reset asserted in WAIT SHALL abandon the access with no write; reset asserted in RESP SHALL drop the pending response.

Configuration
REQ-034 With MEM_RESPONDER_ALIGN_CHECK_EN defined, a word access with addr[1:0] != 0 SHALL respond with rsp_err=1, rsp_rdata=0 and no write.
REQ-035 Without MEM_RESPONDER_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored for word accesses.
REQ-036 Byte accesses SHALL never raise an alignment error.

Structure
REQ-037 A shared package mem_resp_pkg SHALL hold the FSM state enum, the byte/word size encoding, and the WAIT_CYCLES counter width constant.
REQ-038 Lane extract/merge logic SHALL be a combinational sub-module mem_lane_unit with inputs word, byte lane, wdata and byte flag, and outputs merged word and sign-extended read byte.

Verification
REQ-039 Reset, then word write addr=0x10 data=0xDEADBEEF, then word read addr=0x10 -> rdata=0xDEADBEEF, err=0, rsp_valid 3 cycles after accept with WAIT_CYCLES=2.
REQ-040 Word 0x20=0x11223344, then byte write addr=0x22 data=0xAA, then word read 0x20 -> 0x11AA3344; byte read 0x22 -> 0xFFFFFFAA; byte read 0x23 -> 0x00000011.
REQ-041 Word read at addr=0x400 with DEPTH_WORDS=256 -> err=1, rdata=0; with the macro defined, word write 0x12 -> err=1 and word 0x10 unchanged.
REQ-042 rsp_ready held 0 for 5 cycles -> rsp_valid and rdata stable; req_valid=1 throughout -> req_ready=0 until one cycle after the handshake.
REQ-043 Write accepted, reset pulsed during WAIT, then read of the same address -> old value returned; req_ready=1 immediately on reset.
REQ-044 WAIT_CYCLES=0, back-to-back reads with rsp_ready=1 -> one response every 2 cycles, each 1 cycle after its accept.
